program_sequencer: RTL

Run controller sitting between the test harness and the core's fetch/control path. It holds a small table of program start addresses and drives the core's `start`/`start_address` inputs to launch each program in turn. It watches the core's `done` (halt) output and reports a per-program cycle count. An optional watchdog aborts a program that never halts.

---
 rtl/program_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/program_sequencer.sv
// program_sequencer: launches each program from a start-address table on the core and reports its cycle count.
// Optional watchdog abort is compiled in when SEQ_WATCHDOG_EN is defined.
module program_sequencer #(
  parameter int unsigned NUM_PROGS = 3,
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned TIMEOUT   = 4095
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic              go,
  input  logic              core_done,
  output logic              start,
  output logic [ADDR_W-1:0] start_address,
  output logic              busy,
  output logic              all_done,
  output logic [2:0]        prog_idx,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              count_valid,
  output logic              timed_out,
  output logic              timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_REPORT, S_DONE} state_t;

  localparam logic [2:0] LAST_IDX    = 3'(NUM_PROGS - 1);
  localparam logic [3:0] NUM_PROGS_W = 4'(NUM_PROGS);

  state_t            state;
  logic [ADDR_W-1:0] prog_table [8];
  logic [CNT_W-1:0]  counter;
  logic [CNT_W-1:0]  cnt_next;
  logic              table_wr;

  // Saturating increment: the count never wraps back to a small value.
  assign cnt_next = (counter == {CNT_W{1'b1}}) ? counter : counter + CNT_W'(1);
  assign table_wr = cfg_we && !busy && ({1'b0, cfg_idx} < NUM_PROGS_W);

  // Start-address table; writes are locked out while a run is in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) prog_table[i] <= '0;
    end else if (table_wr) begin
      prog_table[cfg_idx] <= cfg_addr;
    end
  end

  // Sequencer state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      start         <= 1'b1;
      start_address <= '0;
      busy          <= 1'b0;
      all_done      <= 1'b0;
      prog_idx      <= '0;
      cycle_count   <= '0;
      count_valid   <= 1'b0;
      counter       <= '0;
`ifdef SEQ_WATCHDOG_EN
      timed_out     <= 1'b0;
      timeout_err   <= 1'b0;
`endif
    end else begin
      count_valid <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      timed_out   <= 1'b0;
`endif
      case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            state         <= S_LAUNCH;
            start         <= 1'b1;
            busy          <= 1'b1;
            all_done      <= 1'b0;
            prog_idx      <= '0;
            start_address <= prog_table[0];
`ifdef SEQ_WATCHDOG_EN
            timeout_err   <= 1'b0;
`endif
          end
        end
        // core_done is a stale halt decode here, so it is not looked at.
        S_LAUNCH: begin
          counter <= '0;
          start   <= 1'b0;
          state   <= S_RUN;
        end
        S_RUN: begin
          if (core_done) begin
            state       <= S_REPORT;
            start       <= 1'b1;
            count_valid <= 1'b1;
            cycle_count <= cnt_next;
          end
`ifdef SEQ_WATCHDOG_EN
          else if (cnt_next == CNT_W'(TIMEOUT)) begin
            state       <= S_REPORT;
            start       <= 1'b1;
            count_valid <= 1'b1;
            cycle_count <= CNT_W'(TIMEOUT);
            timed_out   <= 1'b1;
            timeout_err <= 1'b1;
          end
`endif
          else begin
            counter <= cnt_next;
          end
        end
        S_REPORT: begin
          if (prog_idx == LAST_IDX) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            all_done <= 1'b1;
          end else begin
            prog_idx      <= prog_idx + 3'd1;
            start_address <= prog_table[prog_idx + 3'd1];
            state         <= S_LAUNCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef SEQ_WATCHDOG_EN
  assign timed_out   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
